// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte producers, uart_tx_arbiter and the UART transmitter.
// master = producer/transmitter side, slave = arbiter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_valid;
  logic                          tx_ready;
  logic [ID_W-1:0]               grant_id;
  logic                          lock_abort;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid, grant_id, lock_abort
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, grant_id, lock_abort
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Define UART_ARB_LOCK_EN to keep multi-byte packets (req_last) contiguous, with a lock timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rstn,
  uart_tx_arbiter_if.slave   bus
);
  localparam int ID_W = $clog2(NUM_REQ);

`ifdef UART_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_LOCK = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1
  } state_t;
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [ID_W-1:0]       r_grant;
  logic [ID_W-1:0]       r_last_grant;

  logic [ID_W:0]         w_pick;
  logic [ID_W-1:0]       w_sel;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_last;
  logic [NUM_REQ-1:0]    w_ready;
  logic                  w_accept;
  logic                  w_abort;

`ifdef UART_ARB_LOCK_EN
  logic                  r_last;
  logic [CNT_W-1:0]      r_cnt;
`else
  logic                  w_unused_last;
  assign w_unused_last = ^bus.req_last ^ w_sel_last;
`endif

  // First valid requester strictly after `last`, wrapping; MSB flags that one was found.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    last);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] sel;
    int              idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      sel = ID_W'(idx);
      if (valid[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  assign w_pick = rr_pick(bus.req_valid, r_last_grant);

  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == w_sel) begin
        w_sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_last = bus.req_last[i];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_accept    = 1'b0;
    w_sel       = r_grant;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick[ID_W]) begin
          w_sel          = w_pick[ID_W-1:0];
          w_ready[w_sel] = 1'b1;
          w_accept       = 1'b1;
          w_state_nxt    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.tx_ready) begin
`ifdef UART_ARB_LOCK_EN
          w_state_nxt = r_last ? ST_IDLE : ST_LOCK;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef UART_ARB_LOCK_EN
      ST_LOCK: begin
        // An accept on the timeout cycle takes precedence over the abort.
        if (bus.req_valid[r_grant]) begin
          w_ready[r_grant] = 1'b1;
          w_accept         = 1'b1;
          w_state_nxt      = ST_SEND;
        end else if (r_cnt >= CNT_W'(LOCK_TIMEOUT)) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Accept stage -> transmit holding register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_tx_data    <= '0;
      r_grant      <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_tx_data    <= w_sel_data;
        r_grant      <= w_sel;
        r_last_grant <= w_sel;
      end
    end
  end

`ifdef UART_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_accept) r_last <= w_sel_last;
      // Counter sits at zero outside the lock, so every lock entry starts from zero.
      if (r_state != ST_LOCK) begin
        r_cnt <= '0;
      end else if (!w_accept && (r_cnt < CNT_W'(LOCK_TIMEOUT))) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  assign bus.lock_abort = w_abort;
`else
  assign bus.lock_abort = 1'b0;
`endif

  // req_ready must stay low while reset is held, even though IDLE would otherwise grant.
  assign bus.req_ready = rstn ? w_ready : '0;
  assign bus.tx_valid  = (r_state == ST_SEND);
  assign bus.tx_data   = r_tx_data;
  assign bus.grant_id  = r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle vector table plus hand-written stall/reset/lock sequences.
module tb_uart_tx_arbiter;
  logic clk;
  logic rstn;

  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .LOCK_TIMEOUT(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        txr;
    logic [3:0]  e_ready;
    logic        e_txv;
    logic [7:0]  e_data;
    logic [1:0]  e_gid;
    logic        e_abort;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input bit rst, input logic [3:0] valid, input logic [31:0] data,
                     input logic [3:0] last, input logic txr, input logic [3:0] e_ready,
                     input logic e_txv, input logic [7:0] e_data, input logic [1:0] e_gid,
                     input logic e_abort);
    vec_t v;
    v.rst = rst; v.valid = valid; v.data = data; v.last = last; v.txr = txr;
    v.e_ready = e_ready; v.e_txv = e_txv; v.e_data = e_data; v.e_gid = e_gid;
    v.e_abort = e_abort;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] valid, input logic [31:0] data,
                       input logic [3:0] last, input logic txr);
    bus.req_valid = valid;
    bus.req_data  = data;
    bus.req_last  = last;
    bus.tx_ready  = txr;
  endtask

  // Entered and left at posedge+1; checks reset values while req_valid is high.
  task automatic do_reset();
    rstn = 1'b0;
    drive(4'hF, 32'hDEADBEEF, 4'hF, 1'b1);
    #1;
    check("rst.req_ready", bus.req_ready, 4'h0);
    check("rst.tx_valid", bus.tx_valid, 1'b0);
    check("rst.tx_data", bus.tx_data, 8'h00);
    check("rst.grant_id", bus.grant_id, 2'd0);
    check("rst.lock_abort", bus.lock_abort, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    drive(4'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

`ifdef UART_ARB_LOCK_EN
  task automatic lock_timeout(input bit accept_at_end);
    do_reset();
    drive(4'b1010, 32'h30001000, 4'b1000, 1'b1);
    @(negedge clk);
    check("to.first_ready", bus.req_ready, 4'b0010);
    next_cycle();
    drive(4'b1000, 32'h30001000, 4'b1000, 1'b1);
    @(negedge clk);
    check("to.send_valid", bus.tx_valid, 1'b1);
    next_cycle();
    for (int k = 0; k <= 8; k++) begin
      if (accept_at_end && k == 8) drive(4'b1010, 32'h30001100, 4'b1010, 1'b1);
      @(negedge clk);
      check($sformatf("to%0d.k%0d.abort", accept_at_end, k), bus.lock_abort,
            (k == 8 && !accept_at_end) ? 1'b1 : 1'b0);
      check($sformatf("to%0d.k%0d.ready", accept_at_end, k), bus.req_ready,
            (k == 8 && accept_at_end) ? 4'b0010 : 4'b0000);
      next_cycle();
    end
    if (accept_at_end) begin
      drive(4'b1000, 32'h30001100, 4'b1000, 1'b1);
      @(negedge clk);
      check("to1.tx_data", bus.tx_data, 8'h11);
      check("to1.grant_id", bus.grant_id, 2'd1);
      check("to1.tx_valid", bus.tx_valid, 1'b1);
      next_cycle();
    end else begin
      @(negedge clk);
      check("to0.r3_ready", bus.req_ready, 4'b1000);
      check("to0.abort_gone", bus.lock_abort, 1'b0);
      next_cycle();
      @(negedge clk);
      check("to0.r3_gid", bus.grant_id, 2'd3);
      check("to0.r3_data", bus.tx_data, 8'h30);
      next_cycle();
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    drive(4'h0, 32'h0, 4'h0, 1'b0);

    // Requesters 0 and 2, bytes 0x41 / 0x42.
    add(1, 4'b0101, 32'h00420041, 4'hF, 1, 4'b0001, 0, 8'h00, 2'd0, 0);
    add(0, 4'b0100, 32'h00420041, 4'hF, 1, 4'b0000, 1, 8'h41, 2'd0, 0);
    add(0, 4'b0100, 32'h00420041, 4'hF, 1, 4'b0100, 0, 8'h41, 2'd0, 0);
    add(0, 4'b0000, 32'h00420041, 4'hF, 1, 4'b0000, 1, 8'h42, 2'd2, 0);
    add(0, 4'b0000, 32'h00420041, 4'hF, 1, 4'b0000, 0, 8'h42, 2'd2, 0);

    // All four continuously valid: grants 0,1,2,3,0,1.
    for (int k = 0; k < 6; k++) begin
      int g;
      int p;
      g = k % 4;
      p = (k + 3) % 4;
      add(k == 0, 4'hF, 32'hA3A2A1A0, 4'hF, 1, 4'(1 << g), 0,
          (k == 0) ? 8'h00 : 8'(160 + p), (k == 0) ? 2'd0 : 2'(p), 0);
      add(0, 4'hF, 32'hA3A2A1A0, 4'hF, 1, 4'h0, 1, 8'(160 + g), 2'(g), 0);
    end

`ifdef UART_ARB_LOCK_EN
    // Requester 1 packet 0x10,0x11,0x12 stays contiguous against requester 3.
    add(1, 4'b1010, 32'h30001000, 4'b1000, 1, 4'b0010, 0, 8'h00, 2'd0, 0);
    add(0, 4'b1010, 32'h30001100, 4'b1000, 1, 4'b0000, 1, 8'h10, 2'd1, 0);
    add(0, 4'b1010, 32'h30001100, 4'b1000, 1, 4'b0010, 0, 8'h10, 2'd1, 0);
    add(0, 4'b1010, 32'h30001200, 4'b1010, 1, 4'b0000, 1, 8'h11, 2'd1, 0);
    add(0, 4'b1010, 32'h30001200, 4'b1010, 1, 4'b0010, 0, 8'h11, 2'd1, 0);
    add(0, 4'b1000, 32'h30001200, 4'b1010, 1, 4'b0000, 1, 8'h12, 2'd1, 0);
    add(0, 4'b1000, 32'h30001200, 4'b1010, 1, 4'b1000, 0, 8'h12, 2'd1, 0);
    add(0, 4'b1000, 32'h30001200, 4'b1010, 1, 4'b0000, 1, 8'h30, 2'd3, 0);
`else
    // Without lock, last=0 does not hold the grant.
    add(1, 4'b0011, 32'h00002221, 4'b0000, 1, 4'b0001, 0, 8'h00, 2'd0, 0);
    add(0, 4'b0011, 32'h00002221, 4'b0000, 1, 4'b0000, 1, 8'h21, 2'd0, 0);
    add(0, 4'b0011, 32'h00002221, 4'b0000, 1, 4'b0010, 0, 8'h21, 2'd0, 0);
    add(0, 4'b0011, 32'h00002221, 4'b0000, 1, 4'b0000, 1, 8'h22, 2'd1, 0);
`endif

    next_cycle();
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].txr);
      @(negedge clk);
      check($sformatf("v%0d.req_ready", i), bus.req_ready, vecs[i].e_ready);
      check($sformatf("v%0d.tx_valid", i), bus.tx_valid, vecs[i].e_txv);
      check($sformatf("v%0d.tx_data", i), bus.tx_data, vecs[i].e_data);
      check($sformatf("v%0d.grant_id", i), bus.grant_id, vecs[i].e_gid);
      check($sformatf("v%0d.lock_abort", i), bus.lock_abort, vecs[i].e_abort);
      next_cycle();
    end

    // Transmitter stalls for 20 cycles.
    do_reset();
    drive(4'b0010, 32'h00003300, 4'hF, 1'b0);
    @(negedge clk);
    check("stall.accept", bus.req_ready, 4'b0010);
    next_cycle();
    drive(4'hF, 32'h00003300, 4'hF, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d.tx_valid", k), bus.tx_valid, 1'b1);
      check($sformatf("stall%0d.tx_data", k), bus.tx_data, 8'h33);
      check($sformatf("stall%0d.grant_id", k), bus.grant_id, 2'd1);
      check($sformatf("stall%0d.req_ready", k), bus.req_ready, 4'h0);
      next_cycle();
    end
    bus.tx_ready = 1'b1;
    @(negedge clk);
    check("stall.release_valid", bus.tx_valid, 1'b1);
    check("stall.release_ready", bus.req_ready, 4'h0);
    next_cycle();
    @(negedge clk);
    check("stall.next_grant", bus.req_ready, 4'b0100);
    check("stall.next_idle", bus.tx_valid, 1'b0);
    next_cycle();

    // Asynchronous reset while holding 0x55 from requester 2.
    do_reset();
    drive(4'b0100, 32'h00550000, 4'hF, 1'b0);
    @(negedge clk);
    check("arst.accept", bus.req_ready, 4'b0100);
    next_cycle();
    drive(4'hF, 32'h00550000, 4'hF, 1'b0);
    #2;
    check("arst.pre_valid", bus.tx_valid, 1'b1);
    check("arst.pre_data", bus.tx_data, 8'h55);
    rstn = 1'b0;
    #1;
    check("arst.tx_valid", bus.tx_valid, 1'b0);
    check("arst.tx_data", bus.tx_data, 8'h00);
    check("arst.req_ready", bus.req_ready, 4'h0);
    next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    check("arst.restart_r0", bus.req_ready, 4'b0001);
    next_cycle();

`ifdef UART_ARB_LOCK_EN
    lock_timeout(1'b0);
    lock_timeout(1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
